// File: rtl/pdm_capture_buffer.sv
// PDM microphone capture buffer.
// Generates the mic bit clock, samples one or two PDM channels, decimates each
// by ones-counting into signed PCM words and stores them in an internal buffer
// (single-shot or circular recording).
// Ports:
//   clk, btnC           : clock, synchronous active-high reset
//   record, stop        : single-cycle start / stop requests
//   circular            : recording mode, latched when record is accepted
//   micData, micClk     : PDM data in, PDM bit clock out
//   micLRSel            : mic channel select, tied low (left mic)
//   rd_addr, rd_data    : synchronous buffer read port (1-cycle latency)
//   sample_valid/data/ch: live PCM sample stream
//   busy, done, full    : capture status
//   wr_ptr              : next write address (oldest word once full, circular)
module pdm_capture_buffer #(
  parameter int unsigned CLK_DIV  = 40,
  parameter int unsigned DECIM    = 64,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned NUM_CH   = 1,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                btnC,
  input  logic                record,
  input  logic                stop,
  input  logic                circular,
  input  logic                micData,
  output logic                micClk,
  output logic                micLRSel,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ch,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic [AW-1:0]       wr_ptr
);

  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned DW   = $clog2(CLK_DIV);
  localparam int unsigned CW   = $clog2(DECIM);
  localparam int unsigned OW   = CW + 1;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

  state_t              state;
  logic [DW-1:0]       div_cnt;
  logic [DW-1:0]       div_nxt;
  logic                l_stb;
  logic                r_stb;
  logic                circ;
  logic                last_wr;
  logic [CW-1:0]       l_cnt;
  logic [CW-1:0]       r_cnt;
  logic [OW-1:0]       l_ones;
  logic [OW-1:0]       r_ones;
  logic [OW-1:0]       l_tot;
  logic [OW-1:0]       r_tot;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Left strobe: last cycle of micClk high; right strobe: last cycle of micClk low.
  assign l_stb    = (div_cnt == DW'(CLK_DIV - 1));
  assign r_stb    = (NUM_CH == 2) && (div_cnt == DW'(HALF - 1));
  assign div_nxt  = l_stb ? '0 : div_cnt + DW'(1);
  assign l_tot    = l_ones + OW'(micData);
  assign r_tot    = r_ones + OW'(micData);
  assign busy     = (state != IDLE);
  assign micLRSel = 1'b0;

  // 2*ones - DECIM in two's complement; SAMPLE_W leaves room for the sign.
  function automatic logic [SAMPLE_W-1:0] to_pcm(input logic [OW-1:0] ones);
    return (SAMPLE_W'(ones) << 1) - SAMPLE_W'(DECIM);
  endfunction

  // Free-running bit-clock divider.
  always_ff @(posedge clk) begin
    if (btnC) begin
      div_cnt <= '0;
      micClk  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      micClk  <= (div_nxt >= DW'(HALF));
    end
  end

  // Capture FSM, decimators and write pointer.
  always_ff @(posedge clk) begin
    if (btnC) begin
      state        <= IDLE;
      circ         <= 1'b0;
      last_wr      <= 1'b0;
      l_cnt        <= '0;
      r_cnt        <= '0;
      l_ones       <= '0;
      r_ones       <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= 1'b0;
      done         <= 1'b0;
      full         <= 1'b0;
      wr_ptr       <= '0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      last_wr      <= 1'b0;

      // The buffer write happens in the sample_valid cycle.
      if (sample_valid) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (wr_ptr == AW'(DEPTH - 1)) full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (record && !stop) begin
            circ   <= circular;
            wr_ptr <= '0;
            full   <= 1'b0;
            l_cnt  <= '0;
            r_cnt  <= '0;
            l_ones <= '0;
            r_ones <= '0;
            state  <= ARM;
          end
        end
        ARM: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (l_stb) begin
            l_ones <= OW'(micData);
            l_cnt  <= CW'(1);
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_valid && last_wr) begin
            // Terminating single-shot write; done was already pulsed.
            state <= IDLE;
          end else if (stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            if (l_stb) begin
              if (l_cnt == CW'(DECIM - 1)) begin
                sample_valid <= 1'b1;
                sample_data  <= to_pcm(l_tot);
                sample_ch    <= 1'b0;
                l_ones       <= '0;
                l_cnt        <= '0;
                if (!circ && wr_ptr == AW'(DEPTH - 1)) begin
                  last_wr <= 1'b1;
                  done    <= 1'b1;
                end
              end else begin
                l_ones <= l_tot;
                l_cnt  <= l_cnt + CW'(1);
              end
            end
            if (r_stb) begin
              if (r_cnt == CW'(DECIM - 1)) begin
                sample_valid <= 1'b1;
                sample_data  <= to_pcm(r_tot);
                sample_ch    <= 1'b1;
                r_ones       <= '0;
                r_cnt        <= '0;
                if (!circ && wr_ptr == AW'(DEPTH - 1)) begin
                  last_wr <= 1'b1;
                  done    <= 1'b1;
                end
              end else begin
                r_ones <= r_tot;
                r_cnt  <= r_cnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample buffer with registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!btnC && sample_valid) mem[wr_ptr] <= sample_data;
    if (btnC) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/pdm_capture_buffer.md
# pdm_capture_buffer

Parametrised PDM microphone capture block: generates the mic bit clock, samples one or two PDM channels, decimates each by ones-counting into signed PCM words, and stores them in an internal sample buffer. It supports single-shot and circular recording. It sits between the board mic pins and the speech-recognition core, which reads recorded samples through a synchronous read port or taps the live sample stream.

## Interface
- `CLK_DIV`, 40: clk cycles per micClk period; even, ≥4.
- `DECIM`, 64: PDM bits per PCM sample per channel; power of two, ≥4.
- `SAMPLE_W`, 16: PCM word width; ≥ $clog2(DECIM)+2.
- `DEPTH`, 4096: buffer words, total across channels; power of two.
- `NUM_CH`, 1: channel count, 1 (left only) or 2 (left+right on the shared data line).
- `AW`, $clog2(DEPTH): address width (derived).

Ports:
- `clk` in 1: system clock; the only clock.
- `btnC` in 1: synchronous, active-high reset.
- `record` in 1: start request, single-cycle pulse.
- `stop` in 1: stop request, single-cycle pulse.
- `circular` in 1: mode, sampled on record acceptance; 0 = single-shot, 1 = circular.
- `micData` in 1: PDM data from mic(s).
- `micClk` out 1: PDM bit clock.
- `micLRSel` out 1: tied 0; the single mic is the left/rising-edge channel.
- `rd_addr` in AW: buffer read address.
- `rd_data` out SAMPLE_W: buffer word at rd_addr, registered.
- `sample_valid` out 1: one-cycle strobe for a new PCM sample.
- `sample_data` out SAMPLE_W: signed PCM value, valid with the strobe.
- `sample_ch` out 1: channel of sample_data (0 = left).
- `busy` out 1: armed or capturing.
- `done` out 1: one-cycle pulse when a capture ends.
- `full` out 1: buffer has been completely written since the last start.
- `wr_ptr` out AW: next write address; in circular mode it is the oldest word once full.

## Operation
- Clock divider runs continuously out of reset. micClk = 0 for the first CLK_DIV/2 cycles, then 1 for CLK_DIV/2 cycles, repeating.
- Left strobe: the clk cycle immediately before micClk falls. Right strobe: the cycle immediately before micClk rises. micData is sampled on these strobes; the right strobe is ignored when NUM_CH=1.
- FSM states:
  - IDLE: record accepted when busy=0 and stop=0. On acceptance, latch circular, clear wr_ptr, full and the accumulators, then go to ARM. A record with stop high in the same cycle is dropped. A record while busy is ignored.
  - ARM: wait for the next left strobe. That strobe's bit is the first bit of window 0. Go to CAPTURE.
  - CAPTURE: each channel counts ones over DECIM of its own strobes.
- Window end: the final strobe of a channel's window produces a PCM value one cycle later, with sample_valid=1. The PCM value is 2·ones − DECIM, sign-extended to SAMPLE_W; all-ones gives +DECIM, all-zeros gives −DECIM. The same cycle writes buffer[wr_ptr] and increments wr_ptr modulo DEPTH.
- Stereo: left and right samples are interleaved, left first, at consecutive addresses.
- Single-shot: the write to address DEPTH−1 sets full, pulses done in the same cycle, and goes to IDLE. Later strobes are discarded.
- Circular: wr_ptr wraps and overwrites. full sets on the first wrap and stays set.
- stop in ARM or CAPTURE goes to IDLE the next cycle and pulses done that cycle. A partial window is discarded; a sample write in the same cycle as stop completes. stop in IDLE does nothing.
- The read port is independent of the FSM. rd_data reflects any write that landed at least one cycle earlier.
- sample_valid/sample_data run only in CAPTURE.

## Timing
- Reset values: micClk 0, micLRSel 0, busy 0, done 0, full 0, wr_ptr 0, sample_valid 0, sample_data 0, sample_ch 0, rd_data 0. Divider phase restarts at 0. Buffer contents are not cleared.
- A reset asserted mid-capture aborts with no done pulse. Behaviour is otherwise identical to power-up.
- busy rises the cycle after record is accepted. It falls in the cycle after the terminating write or stop.
- Sample period per channel: DECIM·CLK_DIV cycles.
- First left sample_valid: (DECIM−1)·CLK_DIV + 1 cycles after the ARM-exit strobe.
- Right samples follow left by CLK_DIV/2 cycles.
- Read latency: 1 cycle from rd_addr to rd_data.

## Test plan
Default parameters for all scenarios: CLK_DIV=4, DECIM=8, SAMPLE_W=16, DEPTH=8, NUM_CH=1.
- micData held 1, record, single-shot → eight writes of 0x0008 spaced 32 cycles apart. done pulses with the 8th write; then busy=0, full=1, wr_ptr=0. Reading addresses 0–7 returns 0x0008.
- micData held 0 → samples 0xFFF8. micData toggling each micClk period → samples 0x0000.
- Circular mode, micData=1, stop one cycle after the 10th sample_valid → busy low, done pulse, full=1, wr_ptr=2. No further writes occur.
- NUM_CH=2, micData = micClk (left strobe sees 1, right sees 0) → sample_ch alternates 0/1 with values 0x0008/0xFFF8. Buffer holds the pair interleaved; single-shot ends after 4 pairs.
- record and stop in the same cycle → busy stays 0, no done. A record pulse while busy → ignored; the capture continues unchanged.
- btnC for one cycle mid-capture → all outputs at their reset values the next cycle, no done. A new record then starts a clean capture with wr_ptr=0.
